// File: rtl/seq_match_if.sv
// Word handshake between a producer and seq_match_ctrl.
// The producer drives in_valid and in_data. The controller drives in_ready.
interface seq_match_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seq_match_ctrl.sv
// Serializes accepted words LSB first through an overlapping pattern detector.
// Reports a saturating match count per word, framed by a done pulse.
module seq_match_ctrl #(
  parameter int              WIDTH   = 8,
  parameter int              PLEN    = 3,
  parameter logic [PLEN-1:0] PATTERN = 3'b110,
  parameter int              CNTW    = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  seq_match_if.slave      prod,
  input  logic            clear,
  output logic            w,
  output logic            match,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] match_count
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int FW = $clog2(PLEN + 1);
  localparam logic [IW-1:0]   LAST_IDX = IW'(WIDTH - 1);
  localparam logic [FW-1:0]   FILL_MAX = FW'(PLEN);
  localparam logic [FW-1:0]   FILL_THR = FW'(PLEN - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t            state_r, state_n;
  logic [WIDTH-1:0]  sreg_r;
  logic [WIDTH-1:0]  sreg_shift_s;
  logic [IW-1:0]     idx_r;
  logic [PLEN-1:0]   hist_r;
  logic [PLEN-1:0]   hist_upd_s;
  logic [FW-1:0]     fill_r;
  logic [CNTW-1:0]   count_r;
  logic              w_r, match_r, busy_r, done_r;
  logic              accept_s, clear_s, shift_s, last_s, hit_s;

  // Newest bit enters at the LSB; the oldest bit falls off the MSB.
  function automatic logic [PLEN-1:0] hist_push(input logic [PLEN-1:0] h, input logic b);
    logic [PLEN:0] t;
    t = {h, b};
    return t[PLEN-1:0];
  endfunction

  assign prod.in_ready = (state_r != ST_SHIFT);
  assign w             = w_r;
  assign match         = match_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign match_count   = count_r;

  assign last_s       = (idx_r == LAST_IDX);
  assign sreg_shift_s = sreg_r >> 1'b1;
  assign hist_upd_s   = hist_push(hist_r, sreg_r[0]);

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state decode and per-cycle datapath strobes
  always_comb begin
    state_n  = state_r;
    accept_s = 1'b0;
    clear_s  = 1'b0;
    shift_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        accept_s = prod.in_valid;
        clear_s  = clear;
        if (prod.in_valid) begin
          state_n = ST_SHIFT;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shift_s = 1'b1;
        if (last_s) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_SHIFT;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // A hit needs a history that will be full once the current bit is pushed.
  always_comb begin
    hit_s = 1'b0;
    if (shift_s && (fill_r >= FILL_THR) && (hist_upd_s == PATTERN)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Word datapath: shift register, bit index, serial output and count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sreg_r  <= '0;
      idx_r   <= '0;
      w_r     <= 1'b0;
      match_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      count_r <= '0;
    end else begin
      match_r <= hit_s;
      done_r  <= shift_s && last_s;
      busy_r  <= (state_n == ST_SHIFT);
      if (accept_s) begin
        sreg_r  <= prod.in_data;
        idx_r   <= '0;
        w_r     <= prod.in_data[0];
        count_r <= '0;
      end else if (shift_s) begin
        sreg_r <= sreg_shift_s;
        idx_r  <= idx_r + IW'(1'b1);
        w_r    <= last_s ? 1'b0 : sreg_shift_s[0];
        if (hit_s && (count_r != CNT_MAX)) begin
          count_r <= count_r + CNTW'(1'b1);
        end
      end else begin
        w_r <= 1'b0;
      end
    end
  end

  // Bit history persists across words until clear or reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_r <= '0;
      fill_r <= '0;
    end else if (clear_s) begin
      hist_r <= '0;
      fill_r <= '0;
    end else if (shift_s) begin
      hist_r <= hist_upd_s;
      if (fill_r != FILL_MAX) begin
        fill_r <= fill_r + FW'(1'b1);
      end
    end
  end

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Bench for seq_match_ctrl: a stream-level reference model checked every cycle,
// plus literal expectations for the directed scenarios (DUT b has CNTW=1).
module tb_seq_match_ctrl;
  localparam int W = 8;
  localparam int P = 3;
  localparam logic [P-1:0] PAT = 3'b110;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic clear = 1'b0;
  logic [W-1:0] in_data = '0;

  logic w_a, match_a, busy_a, done_a;
  logic [3:0] cnt_a;
  logic w_b, match_b, busy_b, done_b;
  logic [0:0] cnt_b;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  seq_match_if #(.WIDTH(W)) ifa ();
  seq_match_if #(.WIDTH(W)) ifb ();
  assign ifa.in_valid = in_valid;
  assign ifa.in_data  = in_data;
  assign ifb.in_valid = in_valid;
  assign ifb.in_data  = in_data;

  seq_match_ctrl #(.WIDTH(W), .PLEN(P), .PATTERN(PAT), .CNTW(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .prod(ifa), .clear(clear),
    .w(w_a), .match(match_a), .busy(busy_a), .done(done_a), .match_count(cnt_a));

  seq_match_ctrl #(.WIDTH(W), .PLEN(P), .PATTERN(PAT), .CNTW(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .prod(ifb), .clear(clear),
    .w(w_b), .match(match_b), .busy(busy_b), .done(done_b), .match_count(cnt_b));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase -1 idle, 0..W-1 bit being presented, W done.
  int m_phase = -1;
  logic [W-1:0] m_word = '0;
  bit s[$];
  int m_cnt = 0;
  bit m_match = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = -1;
      s.delete();
      m_cnt = 0;
      m_match = 1'b0;
    end else if (m_phase >= 0 && m_phase < W) begin
      s.push_back(m_word[m_phase]);
      if (s.size() > P) void'(s.pop_front());
      m_match = (s.size() == P);
      for (int i = 0; i < P; i++)
        if (s[i] != PAT[P-1-i]) m_match = 1'b0;
      if (m_match) m_cnt++;
      m_phase++;
    end else begin
      m_match = 1'b0;
      if (clear) s.delete();
      if (in_valid) begin
        m_word = in_data;
        m_cnt = 0;
        m_phase = 0;
      end else begin
        m_phase = -1;
      end
    end
  end

  int done_cyc[$];
  int done_cnt[$];

  always @(negedge clk) begin
    bit sh;
    sh = (m_phase >= 0 && m_phase < W);
    cmp("a_w",     w_a,          sh ? m_word[m_phase] : 1'b0);
    cmp("a_match", match_a,      m_match);
    cmp("a_busy",  busy_a,       sh);
    cmp("a_done",  done_a,       m_phase == W);
    cmp("a_ready", ifa.in_ready, !sh);
    cmp("a_count", cnt_a,        (m_cnt > 15) ? 15 : m_cnt);
    cmp("b_w",     w_b,          sh ? m_word[m_phase] : 1'b0);
    cmp("b_match", match_b,      m_match);
    cmp("b_done",  done_b,       m_phase == W);
    cmp("b_ready", ifb.in_ready, !sh);
    cmp("b_count", cnt_b,        (m_cnt > 0) ? 1 : 0);
    if (done_a) begin
      done_cyc.push_back(cyc);
      done_cnt.push_back(int'(cnt_a));
    end
  end

  logic [8:0] wv, mv, mvb, dv;
  int ca, cb;

  // Accept one word then capture S0..S7 and DONE.
  task automatic send(input logic [W-1:0] d);
    in_data = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = ~d;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      wv[k] = w_a;
      mv[k] = match_a;
      mvb[k] = match_b;
      dv[k] = done_a;
      ca = int'(cnt_a);
      cb = int'(cnt_b);
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #3;
    cmp("rst_ready", ifa.in_ready, 1'b1);
    cmp("rst_busy",  busy_a, 1'b0);
    cmp("rst_count", cnt_a, 4'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    send(8'b0110_1101);
    cmp("single_w",      wv[7:0], 8'b0110_1101);
    cmp("single_match",  mv, 9'b1_0010_0000);
    cmp("single_done",   dv, 9'b1_0000_0000);
    cmp("single_cnt",    ca, 2);
    cmp("sat_cnt",       cb, 1);
    cmp("sat_match",     mvb, 9'b1_0010_0000);

    pulse_clear();
    send(8'b1100_0000);
    cmp("cross1_cnt", ca, 0);
    send(8'b0000_0000);
    cmp("cross2_match", mv, 9'b0_0000_0010);
    cmp("cross2_cnt",   ca, 1);
    send(8'b1100_0000);
    pulse_clear();
    send(8'b0000_0000);
    cmp("clr2_cnt",   ca, 0);
    cmp("clr2_match", mv, 9'b0);

    done_cyc.delete();
    done_cnt.delete();
    in_data = 8'b0110_1101;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 8'hFF;
    repeat (4) @(posedge clk);
    #1 in_data = 8'b0110_1101;
    repeat (5) @(posedge clk);
    #1 in_valid = 1'b0;
    in_data = 8'h00;
    repeat (12) @(posedge clk);
    #1;
    cmp("b2b_ndone", done_cyc.size(), 2);
    if (done_cyc.size() == 2) begin
      cmp("b2b_gap",  done_cyc[1] - done_cyc[0], 9);
      cmp("b2b_cnt0", done_cnt[0], 2);
      cmp("b2b_cnt1", done_cnt[1], 2);
    end

    pulse_clear();
    done_cnt.delete();
    in_data = 8'b0110_1101;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    in_data = 8'hFF;
    repeat (8) @(posedge clk);
    #1;
    cmp("ign_ndone", done_cnt.size(), 1);
    if (done_cnt.size() == 1) cmp("ign_cnt", done_cnt[0], 2);

    in_data = 8'b0110_1101;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    cmp("mrst_busy",  busy_a, 1'b0);
    cmp("mrst_w",     w_a, 1'b0);
    cmp("mrst_ready", ifa.in_ready, 1'b1);
    cmp("mrst_count", cnt_a, 4'd0);
    done_cyc.delete();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    cmp("mrst_nodone", done_cyc.size(), 0);
    send(8'b0110_1101);
    cmp("mrst_cnt", ca, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
